mdio_phy_responder: RTL and testbench

- PHY-side (management-device) end of the IEEE 802.3 Clause 22 MDIO interface; it answers the frames our MAC-side MDC/MDIO master generates.
- Oversamples MDC/MDIO in the local clk domain and decodes preamble, ST, OP, PHYAD, REGAD, TA and DATA.
- Serves reads from a small internal register file; updates that file on writes.
- Drives MDIO through a split tristate (mdio_o/mdio_oe); the top level builds the pad.

---
 rtl/mdio_phy_responder_if.sv | 11 +
 rtl/mdio_phy_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_mdio_phy_responder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_phy_responder_if.sv
// MDIO management bus as seen at the PHY: MDC/MDIO from the master and
// the split tristate returned by the responder.
interface mdio_phy_responder_if;
  logic mdc;
  logic mdio_i;
  logic mdio_o;
  logic mdio_oe;

  modport master (output mdc, output mdio_i, input mdio_o, input mdio_oe);
  modport slave  (input mdc, input mdio_i, output mdio_o, output mdio_oe);
endinterface

// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO PHY-side responder: oversamples MDC/MDIO, decodes frames,
// serves reads from a small register file and commits writes.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'h10,
  parameter int          NUM_REGS = 8,
  parameter int          PRE_LEN  = 32,
  parameter logic [15:0] PHY_ID1  = 16'h0022,
  parameter logic [15:0] PHY_ID2  = 16'h1620
) (
  input  logic                 clk,
  input  logic                 rst,
  mdio_phy_responder_if.slave  mdio,
  output logic [15:0]          ctrl_reg,
  output logic                 wr_strobe,
  output logic [4:0]           wr_addr,
  output logic [15:0]          wr_data
);

  localparam int PCW = $clog2(PRE_LEN + 1);
  localparam int AW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [PCW-1:0] PRE_FULL = PCW'(PRE_LEN);
  localparam logic [5:0]     NREGS    = 6'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
  } state_t;

  logic mdc_meta_reg, mdc_s_reg, mdc_d_reg;
  logic mdio_meta_reg, mdio_s_reg;
  logic rise, bit_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_meta_reg  <= 1'b0;
      mdc_s_reg     <= 1'b0;
      mdc_d_reg     <= 1'b0;
      mdio_meta_reg <= 1'b0;
      mdio_s_reg    <= 1'b0;
    end else begin
      mdc_meta_reg  <= mdio.mdc;
      mdc_s_reg     <= mdc_meta_reg;
      mdc_d_reg     <= mdc_s_reg;
      mdio_meta_reg <= mdio.mdio_i;
      mdio_s_reg    <= mdio_meta_reg;
    end
  end

  assign rise   = mdc_s_reg & ~mdc_d_reg;
  assign bit_in = mdio_s_reg;

  state_t          state_reg, state_next;
  logic [PCW-1:0]  pre_cnt_reg, pre_cnt_next;
  logic [3:0]      bit_cnt_reg, bit_cnt_next;
  logic            is_read_reg, is_read_next;
  logic            match_reg, match_next;
  logic [4:0]      regad_reg, regad_next;
  logic [15:0]     shift_reg, shift_next;
  logic            mdio_o_reg, mdio_o_next;
  logic            mdio_oe_reg, mdio_oe_next;
  logic            wr_strobe_reg, wr_strobe_next;
  logic [4:0]      wr_addr_reg, wr_addr_next;
  logic [15:0]     wr_data_reg, wr_data_next;

  logic            commit;
  logic [15:0]     commit_data;
  logic [4:0]      addr_in;
  logic [15:0]     rd_value;
  logic            soft_rst;
  logic [15:0]     reg_val [NUM_REGS];

  assign addr_in     = {shift_reg[3:0], bit_in};
  assign commit_data = {shift_reg[14:0], bit_in};
  assign soft_rst    = commit && (regad_reg == 5'd0) && commit_data[15];

  // Register file: IDs are constants, everything else below NUM_REGS is R/W.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == 2) begin : g_id1
      assign reg_val[gi] = PHY_ID1;
    end else if (gi == 3) begin : g_id2
      assign reg_val[gi] = PHY_ID2;
    end else begin : g_rw
      logic [15:0] value_reg;
      always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
          value_reg <= 16'h0000;
        end else if (commit && (regad_reg == 5'(gi))) begin
          // Soft-reset bit of register 0 is never stored, so it reads back 0.
          value_reg <= (gi == 0) ? {1'b0, commit_data[14:0]} : commit_data;
        end
      end
      assign reg_val[gi] = value_reg;
    end
  end

  always_comb begin
    rd_value = 16'h0000;
    if ({1'b0, addr_in} < NREGS) begin
      rd_value = reg_val[addr_in[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      pre_cnt_reg   <= '0;
      bit_cnt_reg   <= 4'd0;
      is_read_reg   <= 1'b0;
      match_reg     <= 1'b0;
      regad_reg     <= 5'd0;
      shift_reg     <= 16'h0000;
      mdio_o_reg    <= 1'b1;
      mdio_oe_reg   <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_addr_reg   <= 5'd0;
      wr_data_reg   <= 16'h0000;
    end else begin
      state_reg     <= state_next;
      pre_cnt_reg   <= pre_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      is_read_reg   <= is_read_next;
      match_reg     <= match_next;
      regad_reg     <= regad_next;
      shift_reg     <= shift_next;
      mdio_o_reg    <= mdio_o_next;
      mdio_oe_reg   <= mdio_oe_next;
      wr_strobe_reg <= wr_strobe_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
    end
  end

  // The preamble counter is only advanced in IDLE and is cleared on leaving
  // it, so every return to IDLE starts a fresh preamble.
  always_comb begin
    state_next     = state_reg;
    pre_cnt_next   = pre_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    is_read_next   = is_read_reg;
    match_next     = match_reg;
    regad_next     = regad_reg;
    shift_next     = shift_reg;
    mdio_o_next    = mdio_o_reg;
    mdio_oe_next   = mdio_oe_reg;
    wr_strobe_next = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    commit         = 1'b0;
    if (rise) begin
      case (state_reg)
        S_IDLE: begin
          if (bit_in) begin
            if (pre_cnt_reg != PRE_FULL) pre_cnt_next = pre_cnt_reg + 1'b1;
          end else if (pre_cnt_reg == PRE_FULL) begin
            state_next   = S_ST;
            pre_cnt_next = '0;
          end else begin
            pre_cnt_next = '0;
          end
        end
        S_ST: begin
          bit_cnt_next = 4'd0;
          state_next   = bit_in ? S_OP : S_IDLE;
        end
        S_OP: begin
          shift_next   = {shift_reg[14:0], bit_in};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd1) begin
            bit_cnt_next = 4'd0;
            is_read_next = shift_reg[0];
            state_next   = (shift_reg[0] != bit_in) ? S_PHYAD : S_IDLE;
          end
        end
        S_PHYAD: begin
          shift_next   = {shift_reg[14:0], bit_in};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd4) begin
            bit_cnt_next = 4'd0;
            match_next   = (addr_in == PHY_ADDR);
            state_next   = S_REGAD;
          end
        end
        S_REGAD: begin
          shift_next   = {shift_reg[14:0], bit_in};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd4) begin
            bit_cnt_next = 4'd0;
            regad_next   = addr_in;
            shift_next   = rd_value;
            state_next   = S_TA;
          end
        end
        S_TA: begin
          if (bit_cnt_reg == 4'd0) begin
            bit_cnt_next = 4'd1;
            if (is_read_reg && match_reg) begin
              mdio_oe_next = 1'b1;
              mdio_o_next  = 1'b0;
            end
          end else begin
            bit_cnt_next = 4'd0;
            state_next   = S_DATA;
            if (is_read_reg && match_reg) begin
              mdio_o_next = shift_reg[15];
              shift_next  = {shift_reg[14:0], 1'b0};
            end
          end
        end
        S_DATA: begin
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (is_read_reg) begin
            if (bit_cnt_reg == 4'd15) begin
              mdio_oe_next = 1'b0;
              mdio_o_next  = 1'b1;
              state_next   = S_IDLE;
            end else if (match_reg) begin
              mdio_o_next = shift_reg[15];
              shift_next  = {shift_reg[14:0], 1'b0};
            end
          end else begin
            shift_next = commit_data;
            if (bit_cnt_reg == 4'd15) begin
              state_next = S_IDLE;
              if (match_reg) begin
                commit         = 1'b1;
                wr_strobe_next = 1'b1;
                wr_addr_next   = regad_reg;
                wr_data_next   = commit_data;
              end
            end
          end
        end
        default: begin
          state_next   = S_IDLE;
          pre_cnt_next = '0;
        end
      endcase
    end
  end

  assign mdio.mdio_o  = mdio_o_reg;
  assign mdio.mdio_oe = mdio_oe_reg;
  assign ctrl_reg     = reg_val[0];
  assign wr_strobe    = wr_strobe_reg;
  assign wr_addr      = wr_addr_reg;
  assign wr_data      = wr_data_reg;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: an MDIO master drives directed frames while a
// protocol-level model predicts the line state at every MDC rise and each write.
`timescale 1ns/1ps
module tb_mdio_phy_responder;
  localparam logic [4:0] PHY_ADDR = 5'h10;
  localparam int NUM_REGS = 8;
  localparam int PRE_LEN  = 32;
  localparam int HALF     = 4;
  localparam bit [1:0] OPR = 2'b10;
  localparam bit [1:0] OPW = 2'b01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic master_val = 1'b1;
  logic [15:0] ctrl_reg;
  logic wr_strobe;
  logic [4:0] wr_addr;
  logic [15:0] wr_data;

  mdio_phy_responder_if bus();
  // Open-drain style pad with pull-up: responder wins when it drives.
  assign bus.mdio_i = bus.mdio_oe ? bus.mdio_o : master_val;

  mdio_phy_responder #(
    .PHY_ADDR(PHY_ADDR), .NUM_REGS(NUM_REGS), .PRE_LEN(PRE_LEN),
    .PHY_ID1(16'h0022), .PHY_ID2(16'h1620)
  ) dut (
    .clk(clk), .rst(rst), .mdio(bus),
    .ctrl_reg(ctrl_reg), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int frame_no = 0;
  int slot_no = 0;
  logic slot_chk = 1'b0;
  logic exp_oe = 1'b0;
  logic exp_o = 1'b1;
  logic [20:0] exp_wr_q[$];
  bit [15:0] mregs [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit [15:0] model_read(input bit [4:0] a);
    if (a == 5'd2) return 16'h0022;
    if (a == 5'd3) return 16'h1620;
    if (a >= NUM_REGS) return 16'h0000;
    return mregs[a];
  endfunction

  function automatic void model_write(input bit [4:0] a, input bit [15:0] d);
    if (a == 5'd0 && d[15]) begin
      for (int i = 0; i < 32; i++) mregs[i] = 16'h0000;
    end else if (a < NUM_REGS && a != 5'd2 && a != 5'd3) begin
      mregs[a] = (a == 5'd0) ? (d & 16'h7FFF) : d;
    end
  endfunction

  // Compare process: line state before each MDC rise, and every write strobe.
  always @(negedge clk) begin
    if (slot_chk) begin
      chk($sformatf("f%0d_s%0d_oe", frame_no, slot_no), bus.mdio_oe, exp_oe);
      chk($sformatf("f%0d_s%0d_o", frame_no, slot_no), bus.mdio_o, exp_o);
    end
    if (wr_strobe === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_wr_strobe f%0d: got addr %h data %h expected no strobe",
                 frame_no, wr_addr, wr_data);
      end else begin
        logic [20:0] e;
        e = exp_wr_q.pop_front();
        chk($sformatf("f%0d_wr_addr", frame_no), wr_addr, e[20:16]);
        chk($sformatf("f%0d_wr_data", frame_no), wr_data, e[15:0]);
      end
    end
  end

  // One MDC period: master changes data while MDC is low, raises MDC after HALF clks.
  task automatic slot(input bit b, input bit drv, input bit e_oe, input bit e_o, output bit line);
    @(posedge clk); #1;
    bus.mdc = 1'b0;
    master_val = drv ? b : 1'b1;
    repeat (HALF - 1) @(posedge clk);
    #1;
    exp_oe = e_oe;
    exp_o = e_o;
    slot_chk = 1'b1;
    @(posedge clk); #1;
    slot_chk = 1'b0;
    line = bus.mdio_oe ? bus.mdio_o : master_val;
    bus.mdc = 1'b1;
    repeat (HALF - 1) @(posedge clk);
  endtask

  task automatic frame(input int npre, input bit [1:0] st, input bit [1:0] op,
                       input bit [4:0] phy, input bit [4:0] ra, input bit [15:0] wd,
                       input int rst_at, output bit [15:0] rword);
    bit valid, rd, drive, commit, line, e_oe, e_o;
    bit [15:0] exp_rd;
    bit seq[$];
    int s_ta;
    frame_no++;
    valid  = (npre >= PRE_LEN) && (st == 2'b01) && (op == OPR || op == OPW);
    rd     = (op == OPR);
    drive  = valid && rd && (phy == PHY_ADDR);
    commit = valid && !rd && (phy == PHY_ADDR);
    exp_rd = model_read(ra);
    rword  = 16'h0000;
    seq.push_back(1'b0);
    for (int i = 0; i < npre; i++) seq.push_back(1'b1);
    for (int i = 1; i >= 0; i--) seq.push_back(st[i]);
    for (int i = 1; i >= 0; i--) seq.push_back(op[i]);
    for (int i = 4; i >= 0; i--) seq.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) seq.push_back(ra[i]);
    s_ta = seq.size();
    seq.push_back(1'b1);
    seq.push_back(1'b0);
    for (int i = 15; i >= 0; i--) seq.push_back(wd[i]);
    seq.push_back(1'b1);
    seq.push_back(1'b1);
    for (int s = 0; s < seq.size(); s++) begin
      slot_no = s;
      e_oe = 1'b0;
      e_o = 1'b1;
      if (drive && s == s_ta + 1) begin
        e_oe = 1'b1;
        e_o = 1'b0;
      end else if (drive && s >= s_ta + 2 && s <= s_ta + 17) begin
        e_oe = 1'b1;
        e_o = exp_rd[15 - (s - s_ta - 2)];
      end
      if (commit && s == s_ta + 17) begin
        exp_wr_q.push_back({ra, wd});
        model_write(ra, wd);
      end
      slot(seq[s], !(rd && s >= s_ta && s < s_ta + 18), e_oe, e_o, line);
      if (s >= s_ta + 2 && s <= s_ta + 17) rword[15 - (s - s_ta - 2)] = line;
      if (s == rst_at) begin
        chk($sformatf("f%0d_oe_before_rst", frame_no), bus.mdio_oe, drive);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("f%0d_oe_after_rst", frame_no), bus.mdio_oe, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = 16'h0000;
        repeat (4) @(posedge clk);
        chk($sformatf("f%0d_wr_pending", frame_no), exp_wr_q.size(), 0);
        return;
      end
    end
    chk($sformatf("f%0d_wr_pending", frame_no), exp_wr_q.size(), 0);
    chk($sformatf("f%0d_ctrl_reg", frame_no), ctrl_reg, model_read(5'd0));
  endtask

  task automatic wr(input bit [4:0] ra, input bit [15:0] d);
    bit [15:0] dummy;
    frame(PRE_LEN, 2'b01, OPW, PHY_ADDR, ra, d, -1, dummy);
  endtask

  task automatic rd(input bit [4:0] ra, output bit [15:0] w);
    frame(PRE_LEN, 2'b01, OPR, PHY_ADDR, ra, 16'h0000, -1, w);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit [15:0] w;
    bus.mdc = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 16'h0000;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_oe", bus.mdio_oe, 1'b0);
    chk("rst_o", bus.mdio_o, 1'b1);
    chk("rst_strobe", wr_strobe, 1'b0);
    chk("rst_wr_addr", wr_addr, 5'd0);
    chk("rst_wr_data", wr_data, 16'h0000);
    chk("rst_ctrl_reg", ctrl_reg, 16'h0000);

    // Write then read back, two patterns
    wr(5'd0, 16'h2AAA);
    chk("pin_ctrl_2aaa", ctrl_reg, 16'h2AAA);
    rd(5'd0, w);  chk("pin_rd_reg0", w, 16'h2AAA);
    wr(5'd1, 16'hAAAA);
    rd(5'd1, w);  chk("pin_rd_reg1", w, 16'hAAAA);

    // Read-only IDs
    rd(5'd2, w);  chk("pin_rd_id1", w, 16'h0022);
    wr(5'd2, 16'hFFFF);
    rd(5'd2, w);  chk("pin_rd_id1_after_wr", w, 16'h0022);
    rd(5'd3, w);  chk("pin_rd_id2", w, 16'h1620);

    // Out-of-range address and a high R/W register
    wr(5'd9, 16'h1357);
    rd(5'd9, w);  chk("pin_rd_oor", w, 16'h0000);
    wr(5'd7, 16'h00F1);
    rd(5'd7, w);  chk("pin_rd_reg7", w, 16'h00F1);

    // Wrong PHY address: no drive, no strobe
    frame(PRE_LEN, 2'b01, OPR, 5'h01, 5'd1, 16'h0000, -1, w);
    frame(PRE_LEN, 2'b01, OPW, 5'h01, 5'd1, 16'h5555, -1, w);
    rd(5'd1, w);  chk("pin_rd_reg1_after_mismatch", w, 16'hAAAA);

    // Short preamble, bad opcode, bad start
    frame(PRE_LEN - 1, 2'b01, OPW, PHY_ADDR, 5'd1, 16'hBBBB, -1, w);
    frame(PRE_LEN, 2'b01, 2'b11, PHY_ADDR, 5'd1, 16'hBBBB, -1, w);
    frame(PRE_LEN, 2'b00, OPW, PHY_ADDR, 5'd1, 16'hBBBB, -1, w);
    rd(5'd1, w);  chk("pin_rd_reg1_after_bad", w, 16'hAAAA);
    wr(5'd1, 16'hBBBB);
    rd(5'd1, w);  chk("pin_rd_reg1_bbbb", w, 16'hBBBB);

    // Soft reset via register 0 bit 15
    wr(5'd1, 16'hCCCC);
    wr(5'd0, 16'h8000);
    rd(5'd1, w);  chk("pin_rd_reg1_softrst", w, 16'h0000);
    rd(5'd0, w);  chk("pin_rd_reg0_softrst", w, 16'h0000);
    rd(5'd7, w);  chk("pin_rd_reg7_softrst", w, 16'h0000);

    // Reset in the middle of a read and of a write
    wr(5'd4, 16'h1234);
    rd(5'd4, w);  chk("pin_rd_reg4", w, 16'h1234);
    frame(PRE_LEN, 2'b01, OPR, PHY_ADDR, 5'd4, 16'h0000, 1 + PRE_LEN + 14 + 6, w);
    frame(PRE_LEN, 2'b01, OPW, PHY_ADDR, 5'd5, 16'h4321, 1 + PRE_LEN + 14 + 8, w);
    rd(5'd2, w);  chk("pin_rd_id1_after_rst", w, 16'h0022);
    rd(5'd4, w);  chk("pin_rd_reg4_after_rst", w, 16'h0000);
    rd(5'd5, w);  chk("pin_rd_reg5_after_rst", w, 16'h0000);

    repeat (10) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
